// File: rtl/game_params.sv
// Shared map geometry, writer status codes and the request/state types used by
// the map tile writer and its request queue.
package game_params;

    localparam int MAP_WIDTH  = 13;
    localparam int MAP_HEIGHT = 13;

    localparam logic [1:0] MTW_OK       = 2'b00;
    localparam logic [1:0] MTW_MISMATCH = 2'b01;
    localparam logic [1:0] MTW_RANGE    = 2'b10;

    typedef struct packed {
        logic [3:0]  x;
        logic [3:0]  y;
        logic        cas;
        logic [15:0] expect_tile;
        logic [15:0] tile;
    } mtw_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DEC,
        ST_WR,
        ST_RESP
    } mtw_state_e;

    function automatic logic tile_in_range(input logic [3:0] x, input logic [3:0] y);
        return (int'(x) < MAP_WIDTH) && (int'(y) < MAP_HEIGHT);
    endfunction

    function automatic logic [18:0] tile_addr(input logic [3:0] x, input logic [3:0] y);
        return 19'(y) * 19'(MAP_WIDTH) + 19'(x);
    endfunction

endpackage

// File: rtl/map_req_fifo.sv
// Parameterised synchronous FIFO with combinational head read; pushes when full
// and pops when empty are ignored.
module map_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/map_tile_writer.sv
// Queued read-compare-write controller for the map tile BRAM read/write port;
// one in-order response per accepted tile update request.
module map_tile_writer
    import game_params::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_x,
    input  logic [3:0]  req_y,
    input  logic        req_cas,
    input  logic [15:0] req_expect,
    input  logic [15:0] req_tile,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic [15:0] rsp_old,
    output logic        busy,
    output logic [18:0] bram_addr,
    output logic [15:0] bram_din,
    output logic        bram_we,
    input  logic [15:0] bram_dout,
    output mtw_state_e  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_valid must hold its payload until then. rsp_valid is a one-cycle pulse
    // with no backpressure.

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mtw_req_t        req_in;
    mtw_req_t        head;
    logic [40:0]     fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            pop;

    mtw_state_e  state_q, state_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;
    mtw_req_t    ent_q, ent_d;
    logic [15:0] old_q, old_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic        we_q, we_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] rsp_old_q, rsp_old_d;

    assign req_in = '{x: req_x, y: req_y, cas: req_cas,
                      expect_tile: req_expect, tile: req_tile};
    assign head   = mtw_req_t'(fifo_dout);

    map_req_fifo #(
        .WIDTH ($bits(mtw_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (req_valid),
        .din   (req_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        ent_d       = ent_q;
        old_d       = old_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = 1'b0;
        rsp_valid_d = 1'b0;
        status_d    = status_q;
        rsp_old_d   = rsp_old_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    ent_d = head;
                    if (!tile_in_range(head.x, head.y)) begin
                        status_d    = MTW_RANGE;
                        rsp_old_d   = 16'h0000;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        addr_d   = tile_addr(head.x, head.y);
                        rd_cnt_d = 8'd0;
                        state_d  = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // Address has been stable since entry; dout is valid on the last RD cycle.
                if (rd_cnt_q == 8'(RD_LAT)) begin
                    old_d   = bram_dout;
                    state_d = ST_DEC;
                end else begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                end
            end
            ST_DEC: begin
                if (ent_q.cas && (old_q != ent_q.expect_tile)) begin
                    status_d    = MTW_MISMATCH;
                    rsp_old_d   = old_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    din_d   = ent_q.tile;
                    we_d    = 1'b1;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                status_d    = MTW_OK;
                rsp_old_d   = old_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rd_cnt_q    <= 8'd0;
            ent_q       <= '0;
            old_q       <= 16'h0000;
            addr_q      <= 19'd0;
            din_q       <= 16'h0000;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            status_q    <= 2'b00;
            rsp_old_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            ent_q       <= ent_d;
            old_q       <= old_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            status_q    <= status_d;
            rsp_old_q   <= rsp_old_d;
        end
    end

    assign req_ready  = !fifo_full;
    assign busy       = (fifo_count != '0) || (state_q != ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = status_q;
    assign rsp_old    = rsp_old_q;
    assign bram_addr  = addr_q;
    assign bram_din   = din_q;
    assign bram_we    = we_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_map_tile_writer.sv
// Directed bench for map_tile_writer: queued expectations checked by a monitor,
// plus a second instance built with a two-cycle BRAM read latency.
module tb_map_tile_writer;
    import game_params::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        req_valid, req_ready, req_cas;
    logic [3:0]  req_x, req_y;
    logic [15:0] req_expect, req_tile;
    logic        rsp_valid, busy, bram_we;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_old, bram_din, bram_dout;
    logic [18:0] bram_addr;
    mtw_state_e  dbg_state;

    logic        d2_req_valid, d2_req_ready, d2_req_cas;
    logic [3:0]  d2_req_x, d2_req_y;
    logic [15:0] d2_req_expect, d2_req_tile;
    logic        d2_rsp_valid, d2_busy, d2_bram_we;
    logic [1:0]  d2_rsp_status;
    logic [15:0] d2_rsp_old, d2_bram_din, d2_bram_dout;
    logic [18:0] d2_bram_addr;
    mtw_state_e  d2_dbg_state;

    map_tile_writer #(.FIFO_DEPTH(4), .RD_LAT(1)) u_dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_cas(req_cas), .req_expect(req_expect),
        .req_tile(req_tile), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .rsp_old(rsp_old), .busy(busy), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_we(bram_we), .bram_dout(bram_dout), .dbg_state(dbg_state)
    );

    map_tile_writer #(.FIFO_DEPTH(4), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .req_valid(d2_req_valid), .req_ready(d2_req_ready),
        .req_x(d2_req_x), .req_y(d2_req_y), .req_cas(d2_req_cas), .req_expect(d2_req_expect),
        .req_tile(d2_req_tile), .rsp_valid(d2_rsp_valid), .rsp_status(d2_rsp_status),
        .rsp_old(d2_rsp_old), .busy(d2_busy), .bram_addr(d2_bram_addr), .bram_din(d2_bram_din),
        .bram_we(d2_bram_we), .bram_dout(d2_bram_dout), .dbg_state(d2_dbg_state)
    );

    // BRAM models: latency 1 and latency 2
    logic [15:0] mem1 [0:255];
    logic [15:0] mem2 [0:255];
    logic [15:0] mem2_p;
    always @(posedge clk) begin
        if (bram_we) mem1[bram_addr[7:0]] <= bram_din;
        bram_dout <= mem1[bram_addr[7:0]];
    end
    always @(posedge clk) begin
        if (d2_bram_we) mem2[d2_bram_addr[7:0]] <= d2_bram_din;
        mem2_p       <= mem2[d2_bram_addr[7:0]];
        d2_bram_dout <= mem2_p;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    // {expected cycle or all-ones, status, old}
    logic [49:0] exp_rsp_q [$];
    // {expected cycle or all-ones, addr, din}
    logic [66:0] exp_wr_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or a write
    always @(negedge clk) begin
        logic [49:0] er;
        logic [66:0] ew;
        if (rstn) begin
            if (rsp_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    er = exp_rsp_q.pop_front();
                    chk("rsp_status", 32'(rsp_status), 32'(er[17:16]));
                    chk("rsp_old", 32'(rsp_old), 32'(er[15:0]));
                    if (er[49:18] != 32'hFFFF_FFFF) chk("rsp_cycle", cyc, er[49:18]);
                end
            end
            if (bram_we) begin
                if (exp_wr_q.size() == 0) begin
                    fail_now("unexpected_bram_we");
                end else begin
                    ew = exp_wr_q.pop_front();
                    chk("wr_addr", 32'(bram_addr), 32'(ew[34:16]));
                    chk("wr_din", 32'(bram_din), 32'(ew[15:0]));
                    if (ew[66:35] != 32'hFFFF_FFFF) chk("wr_cycle", cyc, ew[66:35]);
                end
            end
        end
    end

    // Call at a negedge; leaves req_valid high with the sent payload at the
    // negedge after acceptance (c0 = accept edge index).
    task automatic send(input logic [3:0] x, input logic [3:0] y, input logic cas,
                        input logic [15:0] ex, input logic [15:0] tile,
                        input logic do_rsp, input logic [1:0] st, input logic [15:0] old,
                        input int rsp_lat, input logic do_wr, input logic [18:0] waddr,
                        input int wr_lat, output int c0);
        int n;
        req_valid  = 1'b1;
        req_x      = x;
        req_y      = y;
        req_cas    = cas;
        req_expect = ex;
        req_tile   = tile;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now("req_ready_timeout");
            req_valid = 1'b0;
            c0 = -1;
            return;
        end
        @(negedge clk);
        c0 = cyc;
        if (do_rsp)
            exp_rsp_q.push_back({(rsp_lat < 0) ? 32'hFFFF_FFFF : 32'(c0 + rsp_lat), st, old});
        if (do_wr)
            exp_wr_q.push_back({(wr_lat < 0) ? 32'hFFFF_FFFF : 32'(c0 + wr_lat), waddr, tile});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_rsp_q.size() != 0 || exp_wr_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("wait_idle_timeout");
        @(negedge clk);
    endtask

    initial begin
        int c0;
        int ca [6];
        int n;
        int nwe;
        int nrsp;

        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0100 + 16'(i);
            mem2[i] = 16'h0100 + 16'(i);
        end
        mem1[41] = 16'h0009;
        mem1[0]  = 16'h0004;
        mem2[41] = 16'h0009;

        rstn = 1'b0;
        req_valid = 1'b0; req_x = '0; req_y = '0; req_cas = 1'b0; req_expect = '0; req_tile = '0;
        d2_req_valid = 1'b0; d2_req_x = '0; d2_req_y = '0; d2_req_cas = 1'b0;
        d2_req_expect = '0; d2_req_tile = '0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_rsp_old", 32'(rsp_old), 32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_bram_din", 32'(bram_din), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rstn = 1'b1;
        @(negedge clk);

        // Unconditional write: (2,3) -> addr 41, old 0x0009
        send(4'd2, 4'd3, 1'b0, 16'h0000, 16'h0005, 1'b1, MTW_OK, 16'h0009, 5,
             1'b1, 19'd41, 4, c0);
        req_valid = 1'b0;
        wait_idle();

        // CAS mismatch at (0,0): expect 3, current 4
        send(4'd0, 4'd0, 1'b1, 16'h0003, 16'h0000, 1'b1, MTW_MISMATCH, 16'h0004, 4,
             1'b0, 19'd0, -1, c0);
        req_valid = 1'b0;
        wait_idle();

        // Out of range on each axis and both
        send(4'd13, 4'd0, 1'b0, 16'h0000, 16'h1111, 1'b1, MTW_RANGE, 16'h0000, 1,
             1'b0, 19'd0, -1, c0);
        send(4'd0, 4'd13, 1'b0, 16'h0000, 16'h2222, 1'b1, MTW_RANGE, 16'h0000, -1,
             1'b0, 19'd0, -1, c0);
        send(4'd15, 4'd15, 1'b1, 16'h0000, 16'h3333, 1'b1, MTW_RANGE, 16'h0000, -1,
             1'b0, 19'd0, -1, c0);
        req_valid = 1'b0;
        wait_idle();

        // Last valid tile (12,12) -> addr 168; CAS match with new == old still writes
        send(4'd12, 4'd12, 1'b1, 16'h01A8, 16'h01A8, 1'b1, MTW_OK, 16'h01A8, 5,
             1'b1, 19'd168, 4, c0);
        req_valid = 1'b0;
        wait_idle();

        // Six back-to-back requests at (k+1,1) -> addr 14+k; third one is a CAS match
        for (int k = 0; k < 6; k++) begin
            send(4'(k + 1), 4'd1, (k == 2), (k == 2) ? 16'h0110 : 16'h0000,
                 16'h0A00 + 16'(k), 1'b1, MTW_OK, 16'h010E + 16'(k), (k == 0) ? 5 : -1,
                 1'b1, 19'd14 + 19'(k), (k == 0) ? 4 : -1, ca[k]);
        end
        req_valid = 1'b0;
        chk("fifo_accept5_gap", 32'(ca[4] - ca[0]), 32'd4);
        chk("fifo_accept6_gap", 32'(ca[5] - ca[0]), 32'd8);
        wait_idle();

        // Reset asserted during the WR cycle with two requests queued behind it
        send(4'd7, 4'd2, 1'b0, 16'h0000, 16'h0077, 1'b0, MTW_OK, 16'h0000, -1,
             1'b1, 19'd33, 4, c0);
        send(4'd8, 4'd2, 1'b0, 16'h0000, 16'h0088, 1'b0, MTW_OK, 16'h0000, -1,
             1'b0, 19'd0, -1, n);
        send(4'd9, 4'd2, 1'b0, 16'h0000, 16'h0099, 1'b0, MTW_OK, 16'h0000, -1,
             1'b0, 19'd0, -1, n);
        req_valid = 1'b0;
        n = 0;
        while (!bram_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now("wr_cycle_timeout");
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_bram_we", 32'(bram_we), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // RD_LAT = 2 instance: same request as the first write case
        d2_req_valid = 1'b1;
        d2_req_x = 4'd2; d2_req_y = 4'd3; d2_req_cas = 1'b0;
        d2_req_expect = 16'h0000; d2_req_tile = 16'h0005;
        chk("lat2_req_ready", 32'(d2_req_ready), 32'd1);
        @(negedge clk);
        c0 = cyc;
        d2_req_valid = 1'b0;
        nwe = 0;
        nrsp = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (d2_bram_we) begin
                nwe++;
                chk("lat2_wr_cycle", cyc, 32'(c0 + 5));
                chk("lat2_wr_addr", 32'(d2_bram_addr), 32'd41);
                chk("lat2_wr_din", 32'(d2_bram_din), 32'h0005);
            end
            if (d2_rsp_valid) begin
                nrsp++;
                chk("lat2_rsp_cycle", cyc, 32'(c0 + 6));
                chk("lat2_rsp_status", 32'(d2_rsp_status), 32'(MTW_OK));
                chk("lat2_rsp_old", 32'(d2_rsp_old), 32'h0009);
            end
        end
        chk("lat2_num_writes", 32'(nwe), 32'd1);
        chk("lat2_num_rsps", 32'(nrsp), 32'd1);
        chk("lat2_busy_end", 32'(d2_busy), 32'd0);

        chk("exp_rsp_left", 32'(exp_rsp_q.size()), 32'd0);
        chk("exp_wr_left", 32'(exp_wr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
